ifu_fetch_queue: RTL and testbench

//  Parametrised decoupling queue between the icache response side and decode.

---
 rtl/ifu_pkg.sv | 23 ++
 rtl/ifu_fetch_queue_if.sv | 25 ++
 rtl/ifu_epoch_ctr.sv | 38 +++
 rtl/ifu_fetch_queue.sv | 132 +++++++++++++
 tb/tb_ifu_fetch_queue.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared fetch-queue types, default widths and helpers
package ifu_pkg;

   localparam int XLEN_DEF    = 32;
   localparam int EPOCH_W_DEF = 2;
   localparam int INST_W      = 32;

   // Default-width fetch entry; the queue builds an XLEN-parameterised twin of this layout
   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] pred_pc;
      logic                pred_taken;
      logic [INST_W-1:0]   inst;
   } fetch_entry_t;

   localparam int ENTRY_W_DEF = $bits(fetch_entry_t);

   // Packed width of one entry for a given XLEN
   function automatic int entry_width(input int xlen);
      return 2 * xlen + 1 + INST_W;
   endfunction

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// rtl/ifu_fetch_queue_if.sv - valid/ready fetch-entry channel with producer/consumer modports
interface ifu_fetch_queue_if
   import ifu_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int EPOCH_W = EPOCH_W_DEF
);
   logic               valid;
   logic               ready;
   logic [EPOCH_W-1:0] epoch;
   logic [XLEN-1:0]    pc;
   logic [XLEN-1:0]    pred_pc;
   logic               pred_taken;
   logic [INST_W-1:0]  inst;

   modport master (
      output valid, epoch, pc, pred_pc, pred_taken, inst,
      input  ready
   );

   modport slave (
      input  valid, epoch, pc, pred_pc, pred_taken, inst,
      output ready
   );
endinterface

// File: rtl/ifu_epoch_ctr.sv
// rtl/ifu_epoch_ctr.sv - redirect epoch register, stale-response detect, saturating drop counter
module ifu_epoch_ctr
   import ifu_pkg::*;
#(
   parameter int EPOCH_W = EPOCH_W_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i_flush,
   input  logic               i_valid,
   input  logic               i_ready,
   input  logic [EPOCH_W-1:0] i_epoch,
   output logic [EPOCH_W-1:0] o_cur_epoch,
   output logic               o_stale,
   output logic [31:0]        o_drop_cnt
);

   logic [EPOCH_W-1:0] r_epoch;
   logic [31:0]        r_drop_cnt;

   assign o_cur_epoch = r_epoch;
   assign o_stale     = i_valid && (i_epoch != r_epoch);
   assign o_drop_cnt  = r_drop_cnt;

   // Bump epoch on every redirect; count consumed stale responses, holding at all-ones
   always_ff @(posedge clock) begin
      if (reset) begin
         r_epoch    <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (i_flush)
            r_epoch <= r_epoch + EPOCH_W'(1);
         if (o_stale && i_ready && (r_drop_cnt != 32'hFFFF_FFFF))
            r_drop_cnt <= r_drop_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/ifu_fetch_queue.sv
// rtl/ifu_fetch_queue.sv - epoch-tagged icache-to-decode queue with optional empty bypass
module ifu_fetch_queue
   import ifu_pkg::*;
#(
   parameter int XLEN         = XLEN_DEF,
   parameter int DEPTH        = 4,
   parameter int EPOCH_W      = EPOCH_W_DEF,
   parameter int AFULL_THRESH = DEPTH - 1,
   parameter int BYPASS       = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       i_flush,
   input  logic                       i_stall,
   ifu_fetch_queue_if.slave           s_in,
   ifu_fetch_queue_if.master          m_out,
   output logic [EPOCH_W-1:0]         o_cur_epoch,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_almost_full,
   output logic [31:0]                o_drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pred_pc;
      logic              pred_taken;
      logic [INST_W-1:0] inst;
   } entry_t;

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_almost_full;

   logic [CNT_W-1:0]   w_count_nxt;
   logic [EPOCH_W-1:0] w_cur_epoch;
   logic               w_stale;
   logic               w_empty;
   logic               w_full;
   logic               w_byp_avail;
   logic               w_byp_take;
   logic               w_out_valid;
   logic               w_pop;
   logic               w_pop_q;
   logic               w_push;
   logic               w_in_ready;
   entry_t             w_in_entry;
   entry_t             w_head;

   ifu_epoch_ctr #(.EPOCH_W(EPOCH_W)) u_epoch_ctr (
      .clock       (clock),
      .reset       (reset),
      .i_flush     (i_flush),
      .i_valid     (s_in.valid),
      .i_ready     (w_in_ready),
      .i_epoch     (s_in.epoch),
      .o_cur_epoch (w_cur_epoch),
      .o_stale     (w_stale),
      .o_drop_cnt  (o_drop_cnt)
   );

   assign w_in_entry = '{pc: s_in.pc, pred_pc: s_in.pred_pc,
                         pred_taken: s_in.pred_taken, inst: s_in.inst};

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));

   // A fresh response into an empty queue is visible to decode this cycle
   assign w_byp_avail = (BYPASS != 0) && w_empty && s_in.valid && !w_stale && !i_flush;
   assign w_out_valid = !i_flush && (!w_empty || w_byp_avail);
   assign w_pop       = w_out_valid && m_out.ready && !i_stall;
   // A pop while empty can only be the bypassed entry; it never touches storage
   assign w_byp_take  = w_byp_avail && w_pop;
   assign w_pop_q     = w_pop && !w_empty;
   assign w_in_ready  = !w_full || w_pop;
   assign w_push      = s_in.valid && w_in_ready && !w_stale && !i_flush && !w_byp_take;
   assign w_head      = w_empty ? w_in_entry : r_mem[r_rd_ptr];

   assign s_in.ready       = w_in_ready;
   assign m_out.valid      = w_out_valid;
   assign m_out.epoch      = w_cur_epoch;
   assign m_out.pc         = w_head.pc;
   assign m_out.pred_pc    = w_head.pred_pc;
   assign m_out.pred_taken = w_head.pred_taken;
   assign m_out.inst       = w_head.inst;

   assign o_cur_epoch   = w_cur_epoch;
   assign o_count       = r_count;
   assign o_almost_full = r_almost_full;

   // Next occupancy: redirect empties the queue, otherwise push minus storage pop
   always_comb begin
      w_count_nxt = r_count;
      if (i_flush)
         w_count_nxt = '0;
      else
         w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop_q);
   end

   // Occupancy, pointers and almost-full flag (taken from the post-update count)
   always_ff @(posedge clock) begin
      if (reset) begin
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_almost_full <= 1'b0;
      end else begin
         r_count       <= w_count_nxt;
         r_almost_full <= (w_count_nxt >= CNT_W'(AFULL_THRESH));
         if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_push)
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_q)
               r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
      end
   end

   // Entry storage; contents need no reset since count gates visibility
   always_ff @(posedge clock) begin
      if (w_push)
         r_mem[r_wr_ptr] <= w_in_entry;
   end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb/tb_ifu_fetch_queue.sv - directed scoreboard bench for ifu_fetch_queue
module tb_ifu_fetch_queue;
   import ifu_pkg::*;

   localparam int XLEN    = 32;
   localparam int DEPTH   = 4;
   localparam int EPOCH_W = 2;
   localparam int CNT_W   = $clog2(DEPTH + 1);

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               flush = 1'b0;
   logic               stall = 1'b0;
   logic [EPOCH_W-1:0] cur_epoch;
   logic [CNT_W-1:0]   count;
   logic               almost_full;
   logic [31:0]        drop_cnt;

   int                 vectors     = 0;
   int                 miscompares = 0;
   fetch_entry_t       sb[$];
   logic [EPOCH_W-1:0] m_epoch = '0;

   ifu_fetch_queue_if #(.XLEN(XLEN), .EPOCH_W(EPOCH_W)) in_if ();
   ifu_fetch_queue_if #(.XLEN(XLEN), .EPOCH_W(EPOCH_W)) out_if ();

   ifu_fetch_queue #(
      .XLEN(XLEN), .DEPTH(DEPTH), .EPOCH_W(EPOCH_W),
      .AFULL_THRESH(DEPTH - 1), .BYPASS(1)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .i_flush       (flush),
      .i_stall       (stall),
      .s_in          (in_if),
      .m_out         (out_if),
      .o_cur_epoch   (cur_epoch),
      .o_count       (count),
      .o_almost_full (almost_full),
      .o_drop_cnt    (drop_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [EPOCH_W-1:0] ep, input logic [31:0] pc);
      in_if.valid      = v;
      in_if.epoch      = ep;
      in_if.pc         = pc;
      in_if.pred_pc    = pc + 32'd8;
      in_if.pred_taken = pc[2];
      in_if.inst       = pc ^ 32'h0000_0013;
   endtask

   // One clock: at the falling edge record accepted fresh entries and check any pop
   task automatic cyc();
      fetch_entry_t e;
      fetch_entry_t h;
      @(negedge clock);
      if (reset) begin
         sb.delete();
         m_epoch = '0;
      end else begin
         if (in_if.valid && in_if.ready && !flush && (in_if.epoch == m_epoch)) begin
            e.pc         = in_if.pc;
            e.pred_pc    = in_if.pc + 32'd8;
            e.pred_taken = in_if.pc[2];
            e.inst       = in_if.pc ^ 32'h0000_0013;
            sb.push_back(e);
         end
         if (out_if.valid && out_if.ready && !stall) begin
            if (sb.size() == 0) begin
               chk("pop_unexpected", 64'(out_if.valid), 64'd0);
            end else begin
               h = sb.pop_front();
               chk("pop_pc",      64'(out_if.pc),         64'(h.pc));
               chk("pop_pred_pc", 64'(out_if.pred_pc),    64'(h.pred_pc));
               chk("pop_taken",   64'(out_if.pred_taken), 64'(h.pred_taken));
               chk("pop_inst",    64'(out_if.inst),       64'(h.inst));
            end
         end
         if (flush) begin
            sb.delete();
            m_epoch = m_epoch + EPOCH_W'(1);
         end
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      drive(1'b0, '0, 32'h0);
      out_if.ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_count",  64'(count),        64'd0);
      chk("rst_valid",  64'(out_if.valid), 64'd0);
      chk("rst_epoch",  64'(cur_epoch),    64'd0);
      chk("rst_afull",  64'(almost_full),  64'd0);
      chk("rst_drop",   64'(drop_cnt),     64'd0);

      // Fill to DEPTH with decode held off, then drain in order
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'd0, 32'h3000_0000 + 32'(4 * i));
         #1;
         chk("fill_in_ready", 64'(in_if.ready), 64'd1);
         cyc();
      end
      drive(1'b0, 2'd0, 32'h0);
      #1;
      chk("full_count",    64'(count),       64'd4);
      chk("full_in_ready", 64'(in_if.ready), 64'd0);
      chk("full_afull",    64'(almost_full), 64'd1);
      out_if.ready = 1'b1;
      repeat (4) cyc();
      chk("drain_count", 64'(count),        64'd0);
      chk("drain_afull", 64'(almost_full),  64'd0);
      chk("drain_valid", 64'(out_if.valid), 64'd0);

      // Empty-queue bypass: same-cycle delivery, nothing stored
      drive(1'b1, 2'd0, 32'h3000_0010);
      #1;
      chk("byp_valid", 64'(out_if.valid), 64'd1);
      chk("byp_pc",    64'(out_if.pc),    64'h3000_0010);
      cyc();
      drive(1'b0, 2'd0, 32'h0);
      #1;
      chk("byp_count", 64'(count), 64'd0);

      // Flush with two entries, then a stale response is consumed and counted
      out_if.ready = 1'b0;
      drive(1'b1, 2'd0, 32'h3000_0020);
      cyc();
      drive(1'b1, 2'd0, 32'h3000_0024);
      cyc();
      drive(1'b0, 2'd0, 32'h0);
      #1;
      chk("pre_flush_count", 64'(count), 64'd2);
      flush = 1'b1;
      #1;
      chk("flush_valid", 64'(out_if.valid), 64'd0);
      cyc();
      flush = 1'b0;
      #1;
      chk("post_flush_count", 64'(count),        64'd0);
      chk("post_flush_valid", 64'(out_if.valid), 64'd0);
      chk("post_flush_epoch", 64'(cur_epoch),    64'd1);
      drive(1'b1, 2'd0, 32'h3000_0030);
      #1;
      chk("stale_in_ready", 64'(in_if.ready),  64'd1);
      chk("stale_valid",    64'(out_if.valid), 64'd0);
      cyc();
      drive(1'b0, 2'd0, 32'h0);
      #1;
      chk("stale_drop", 64'(drop_cnt), 64'd1);
      chk("stale_count", 64'(count),   64'd0);

      // Full queue with simultaneous push and pop
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, m_epoch, 32'h3000_0040 + 32'(4 * i));
         cyc();
      end
      chk("full2_count", 64'(count), 64'd4);
      out_if.ready = 1'b1;
      drive(1'b1, m_epoch, 32'h3000_0050);
      #1;
      chk("pushpop_in_ready", 64'(in_if.ready), 64'd1);
      cyc();
      chk("pushpop_count1", 64'(count), 64'd4);
      drive(1'b1, m_epoch, 32'h3000_0054);
      cyc();
      chk("pushpop_count2", 64'(count), 64'd4);
      drive(1'b0, m_epoch, 32'h0);
      repeat (4) cyc();
      chk("drain2_count", 64'(count), 64'd0);

      // Stall holds the head stable
      out_if.ready = 1'b0;
      drive(1'b1, m_epoch, 32'h3000_0060);
      cyc();
      drive(1'b0, m_epoch, 32'h0);
      out_if.ready = 1'b1;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_valid", 64'(out_if.valid), 64'd1);
         chk("stall_pc",    64'(out_if.pc),    64'h3000_0060);
         cyc();
      end
      chk("stall_count", 64'(count), 64'd1);
      stall = 1'b0;
      cyc();
      chk("unstall_count", 64'(count), 64'd0);

      // 2**EPOCH_W back-to-back redirects walk the epoch through its wrap
      out_if.ready = 1'b0;
      flush = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("wrap_epoch", 64'(cur_epoch), 64'(m_epoch));
      end
      flush = 1'b0;
      chk("wrap_final_epoch", 64'(cur_epoch), 64'd1);

      // Mid-operation reset with three entries queued
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, m_epoch, 32'h3000_0070 + 32'(4 * i));
         cyc();
      end
      drive(1'b1, m_epoch + EPOCH_W'(1), 32'h3000_0080);
      cyc();
      drive(1'b0, m_epoch, 32'h0);
      #1;
      chk("pre_rst_count", 64'(count),    64'd3);
      chk("pre_rst_drop",  64'(drop_cnt), 64'd2);
      chk("pre_rst_afull", 64'(almost_full), 64'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("mid_rst_count",    64'(count),        64'd0);
      chk("mid_rst_valid",    64'(out_if.valid), 64'd0);
      chk("mid_rst_epoch",    64'(cur_epoch),    64'd0);
      chk("mid_rst_afull",    64'(almost_full),  64'd0);
      chk("mid_rst_drop",     64'(drop_cnt),     64'd0);
      chk("mid_rst_in_ready", 64'(in_if.ready),  64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
